// File: rtl/jtpang_pcm_romrq.sv
// jtpang_pcm_romrq
// PCM sample-ROM fetch adapter. Serves the ADPCM decoder's byte reads from a
// two-entry 16-bit word cache and fills misses through a single SDRAM
// request/acknowledge transaction. With PREFETCH=1 every demand fill is
// followed by a fetch of the next sequential word so nibble streaming mostly
// hits in the cache.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   pcm_addr   byte address from the decoder
//   pcm_data   byte read from the cache (registered)
//   pcm_ok     pcm_data is valid for the current pcm_addr
//   sdram_addr word address of the SDRAM request (stable while sdram_req)
//   sdram_req  request, held until sdram_ack
//   sdram_ack  request accepted (1-cycle pulse)
//   sdram_dok  sdram_data valid (1-cycle pulse)
//   sdram_data read word
module jtpang_pcm_romrq #(
  parameter int PREFETCH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [17:0] pcm_addr,
  output logic [7:0]  pcm_data,
  output logic        pcm_ok,
  output logic [16:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        sdram_dok,
  input  logic [15:0] sdram_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;
  typedef enum logic {KIND_DEMAND, KIND_PREFETCH} kind_t;

  state_t      state;
  kind_t       kind;

  logic [16:0] tag   [2];
  logic [15:0] data  [2];
  logic        valid [2];
  logic        mru;

  logic [17:0] addr_l;
  logic        ok_r;
  logic        pf_pend;
  logic [16:0] pf_addr;

  logic [16:0] w;
  logic        hit0, hit1, hit;
  logic [15:0] hit_data;
  logic        pf_hit;
  logic        fill_idx;
  logic        dup_other;

  assign w        = pcm_addr[17:1];
  assign fill_idx = ~mru;

  always_comb begin
    hit0      = valid[0] && (tag[0] == w);
    hit1      = valid[1] && (tag[1] == w);
    hit       = hit0 || hit1;
    hit_data  = hit1 ? data[1] : data[0];
    pf_hit    = (valid[0] && (tag[0] == pf_addr)) ||
                (valid[1] && (tag[1] == pf_addr));
    // The entry not being filled (mru) must not keep the same tag.
    dup_other = valid[mru] && (tag[mru] == sdram_addr);
  end

  assign pcm_ok = ok_r && (pcm_addr == addr_l);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      kind       <= KIND_DEMAND;
      for (int unsigned i = 0; i < 2; i++) valid[i] <= 1'b0;
      mru        <= 1'b0;
      addr_l     <= '0;
      ok_r       <= 1'b0;
      pcm_data   <= '0;
      pf_pend    <= 1'b0;
      pf_addr    <= '0;
      sdram_addr <= '0;
      sdram_req  <= 1'b0;
    end else begin
      // Lookup runs every cycle, independent of the fetch state.
      addr_l <= pcm_addr;
      if (hit) begin
        pcm_data <= pcm_addr[0] ? hit_data[15:8] : hit_data[7:0];
        ok_r     <= 1'b1;
        mru      <= hit1;
      end else begin
        ok_r <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (!hit) begin
            sdram_addr <= w;
            kind       <= KIND_DEMAND;
            sdram_req  <= 1'b1;
            state      <= ST_REQ;
          end else if (pf_pend) begin
            pf_pend <= 1'b0;
            if (!pf_hit) begin
              sdram_addr <= pf_addr;
              kind       <= KIND_PREFETCH;
              sdram_req  <= 1'b1;
              state      <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sdram_dok) begin
            tag[fill_idx]   <= sdram_addr;
            data[fill_idx]  <= sdram_data;
            valid[fill_idx] <= 1'b1;
            if (dup_other) valid[mru] <= 1'b0;
            // Fill overrides the lookup's mru update so the next fill
            // does not overwrite the word just fetched.
            mru   <= fill_idx;
            state <= ST_IDLE;
            if (kind == KIND_DEMAND && PREFETCH != 0) begin
              pf_pend <= 1'b1;
              pf_addr <= sdram_addr + 17'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtpang_pcm_romrq.sv
module tb_jtpang_pcm_romrq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] pcm_addr = '0;
  logic [7:0]  pcm_data;
  logic        pcm_ok;
  logic [16:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack = 1'b0;
  logic        sdram_dok = 1'b0;
  logic [15:0] sdram_data = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_req = 0;
  int set_cyc = 0;
  int pop_cyc = 0;
  int dok_cyc = 0;
  bit rule_chk = 1'b0;
  logic [16:0] last_req = '0;
  logic [16:0] req_log [$];

  typedef struct packed {
    logic [17:0] addr;
    logic [7:0]  data;
  } exp_t;
  exp_t exp_q [$];

  jtpang_pcm_romrq #(.PREFETCH(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pcm_addr   (pcm_addr),
    .pcm_data   (pcm_data),
    .pcm_ok     (pcm_ok),
    .sdram_addr (sdram_addr),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .sdram_dok  (sdram_dok),
    .sdram_data (sdram_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SDRAM contents: word 0 holds 0xBEEF, the rest a scrambled pattern.
  function automatic logic [15:0] mem_word(input logic [16:0] wa);
    logic [31:0] x;
    if (wa == 17'd0) return 16'hBEEF;
    x = {15'd0, wa} * 32'd40503 + 32'h1234;
    return x[31:16] ^ x[15:0];
  endfunction

  function automatic logic [7:0] mem_byte(input logic [17:0] ba);
    logic [15:0] m;
    m = mem_word(ba[17:1]);
    return ba[0] ? m[15:8] : m[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: pops one expectation whenever the DUT reports pcm_ok.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && pcm_ok === 1'b1) begin
        e = exp_q.pop_front();
        pop_cyc = cyc;
        chk("sb_data", {24'd0, pcm_data}, {24'd0, e.data});
        chk("sb_addr", {14'd0, pcm_addr}, {14'd0, e.addr});
      end
    end
  end

  task automatic read_start(input logic [17:0] a);
    exp_q.push_back('{addr: a, data: mem_byte(a)});
    pcm_addr = a;
    set_cyc = cyc;
  endtask

  task automatic ack_phase(input int dly, output logic [16:0] a);
    logic [16:0] nxt;
    a = sdram_addr;
    req_log.push_back(a);
    n_req++;
    nxt = last_req + 17'd1;
    if (rule_chk) chk("req_rule", {31'd0, (a == pcm_addr[17:1]) || (a == nxt)}, 32'd1);
    last_req = a;
    repeat (dly) begin
      @(posedge clk); #1;
      chk("req_hold", {31'd0, sdram_req}, 32'd1);
      chk("addr_stable", {15'd0, sdram_addr}, {15'd0, a});
    end
    sdram_ack = 1'b1;
    @(posedge clk); #1;
    sdram_ack = 1'b0;
    chk("req_drop", {31'd0, sdram_req}, 32'd0);
  endtask

  task automatic dok_phase(input logic [16:0] a, input int dly, input bit ok0);
    repeat (dly) begin
      @(posedge clk); #1;
      if (ok0) chk("ok_low_wait", {31'd0, pcm_ok}, 32'd0);
    end
    sdram_data = mem_word(a);
    sdram_dok = 1'b1;
    dok_cyc = cyc;
    @(posedge clk); #1;
    sdram_dok = 1'b0;
    sdram_data = 16'($urandom);
  endtask

  task automatic serve(input int ad, input int dd);
    logic [16:0] a;
    ack_phase(ad, a);
    dok_phase(a, dd, 1'b0);
  endtask

  // Wait for the scoreboard to drain, serving at most max_srv requests.
  task automatic wait_done(input int max_srv, input int ad, input int dd);
    int srv;
    srv = 0;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) return;
      @(posedge clk); #1;
      if (exp_q.size() == 0) return;
      if (sdram_req && srv < max_srv) begin
        serve(ad, dd);
        srv++;
      end
    end
    checks++;
    errors++;
    $display("FAIL read_timeout actual=pending required=done addr=%0h", pcm_addr);
    exp_q.delete();
  endtask

  task automatic drain(input int n, input int ad, input int dd);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (sdram_req) serve(ad, dd);
    end
  endtask

  task automatic wait_req(input int n);
    for (int i = 0; i < n; i++) begin
      if (sdram_req) return;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [16:0] a;
    logic [16:0] prev_w;
    logic [17:0] ra;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ok", {31'd0, pcm_ok}, 32'd0);
    chk("rst_data", {24'd0, pcm_data}, 32'd0);
    chk("rst_req", {31'd0, sdram_req}, 32'd0);
    chk("rst_addr", {15'd0, sdram_addr}, 32'd0);

    // Demand miss to byte 1, ack 2 cycles after req, dok 3 after ack
    rst_n = 1'b1;
    read_start(18'h00001);
    wait_done(1, 2, 3);
    chk("t1_req_addr", {15'd0, req_log[0]}, 32'h0);
    chk("t1_dok_to_ok", pop_cyc - dok_cyc, 32'd2);
    chk("t1_data", {24'd0, pcm_data}, 32'hBE);
    drain(10, 0, 0);
    chk("t1_nreq", n_req, 32'd2);
    chk("t1_pf_addr", {15'd0, req_log[1]}, 32'h1);
    n0 = n_req;
    read_start(18'h00000);
    wait_done(0, 0, 0);
    chk("t1_hit_lat", pop_cyc - set_cyc, 32'd1);
    drain(5, 0, 0);
    chk("t1_no_req", n_req, n0);

    // Prefetch after demand W=0x10
    n0 = n_req;
    read_start(18'h00020);
    wait_done(1, 1, 1);
    drain(10, 0, 1);
    chk("t2_nreq", n_req, n0 + 2);
    chk("t2_demand", {15'd0, req_log[n0]}, 32'h10);
    chk("t2_prefetch", {15'd0, req_log[n0 + 1]}, 32'h11);
    read_start(18'h00022);
    wait_done(0, 0, 0);
    chk("t2_lat22", pop_cyc - set_cyc, 32'd1);
    read_start(18'h00023);
    wait_done(0, 0, 0);
    chk("t2_lat23", pop_cyc - set_cyc, 32'd1);
    drain(5, 0, 0);
    chk("t2_no_req", n_req, n0 + 2);

    // Prefetch address wraps
    n0 = n_req;
    read_start(18'h3FFFE);
    wait_done(1, 0, 2);
    drain(10, 1, 0);
    chk("t3_demand", {15'd0, req_log[n0]}, 32'h1FFFF);
    chk("t3_wrap", {15'd0, req_log[n0 + 1]}, 32'h0);
    read_start(18'h00000);
    wait_done(0, 0, 0);
    chk("t3_lat", pop_cyc - set_cyc, 32'd1);
    chk("t3_no_req", n_req, n0 + 2);

    // Demand miss while a prefetch is in WAIT
    n0 = n_req;
    read_start(18'h00040);
    wait_done(1, 1, 1);
    wait_req(10);
    chk("t4_pf_req", {31'd0, sdram_req}, 32'd1);
    if (sdram_req) begin
      ack_phase(1, a);
      chk("t4_pf_addr", {15'd0, a}, 32'h21);
      read_start(18'h00100);
      dok_phase(a, 4, 1'b1);
      wait_done(1, 1, 1);
      chk("t4_nreq", n_req, n0 + 3);
      chk("t4_demand", {15'd0, req_log[n0 + 2]}, 32'h80);
    end

    // Reset during WAIT, then a late dok with bogus data
    drain(12, 0, 0);
    n0 = n_req;
    read_start(18'h00200);
    wait_req(10);
    chk("t5_req", {31'd0, sdram_req}, 32'd1);
    if (sdram_req) begin
      ack_phase(0, a);
      chk("t5_addr", {15'd0, a}, 32'h100);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("t5_req_low", {31'd0, sdram_req}, 32'd0);
      chk("t5_ok_low", {31'd0, pcm_ok}, 32'd0);
      sdram_data = ~mem_word(17'h100);
      sdram_dok = 1'b1;
      @(posedge clk); #1;
      sdram_dok = 1'b0;
      wait_done(1, 0, 0);
      chk("t5_nreq", n_req, n0 + 2);
      chk("t5_reissue", {15'd0, req_log[n0 + 1]}, 32'h100);
    end

    // Spurious ack/dok while idle
    drain(12, 0, 0);
    n0 = n_req;
    read_start(18'h00203);
    wait_done(0, 0, 0);
    chk("t6_lat_pre", pop_cyc - set_cyc, 32'd1);
    for (int i = 0; i < 3; i++) begin
      sdram_ack = 1'b1;
      @(posedge clk); #1;
      sdram_ack = 1'b0;
      chk("t6_req_ack", {31'd0, sdram_req}, 32'd0);
      sdram_data = 16'($urandom);
      sdram_dok = 1'b1;
      @(posedge clk); #1;
      sdram_dok = 1'b0;
      chk("t6_req_dok", {31'd0, sdram_req}, 32'd0);
    end
    read_start(18'h00200);
    wait_done(0, 0, 0);
    chk("t6_lat_a", pop_cyc - set_cyc, 32'd1);
    read_start(18'h00203);
    wait_done(0, 0, 0);
    chk("t6_lat_b", pop_cyc - set_cyc, 32'd1);
    chk("t6_no_req", n_req, n0);

    // Randomized reads in a small window
    rule_chk = 1'b1;
    last_req = req_log[req_log.size() - 1];
    prev_w = pcm_addr[17:1];
    for (int i = 0; i < 150; i++) begin
      ra = 18'h00400 + 18'($urandom_range(0, 23));
      n0 = n_req;
      read_start(ra);
      if (ra[17:1] == prev_w) begin
        wait_done(0, 0, 0);
        chk("rnd_same_lat", {31'd0, (pop_cyc - set_cyc) <= 1}, 32'd1);
        chk("rnd_same_noreq", n_req, n0);
      end else begin
        wait_done(2, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      prev_w = ra[17:1];
    end
    drain(12, 0, 0);
    rule_chk = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtpang_pcm_romrq.md
# jtpang_pcm_romrq

PCM sample-ROM fetch adapter between the ADPCM decoder's byte ROM port and the SDRAM 16-bit read channel. It serves the decoder's byte reads from a two-entry word cache. On a miss it issues one request/acknowledge transaction to SDRAM. After each demand fill it can prefetch the next sequential word, so nibble streaming runs mostly from cache.

## Interface
Parameters:
- PREFETCH, 1, enables the sequential next-word prefetch after each demand fill (0 = demand fetches only).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- pcm_addr  in  18  byte address from the decoder.
- pcm_data  out  8  byte read from the cache.
- pcm_ok  out  1  pcm_data is valid for the current pcm_addr.
- sdram_addr  out  17  word address of the SDRAM request.
- sdram_req  out  1  request; held high until accepted.
- sdram_ack  in  1  request accepted (1-cycle pulse).
- sdram_dok  in  1  sdram_data valid (1-cycle pulse); arrives after sdram_ack.
- sdram_data  in  16  read word.

## Operation
- Word address W = pcm_addr[17:1]. Byte select: pcm_addr[0]=0 → data[7:0]; pcm_addr[0]=1 → data[15:8].
- Cache: entries E0 and E1, each holding tag[16:0], valid and data[15:0]. A 1-bit pointer `mru` records the last entry hit or filled. Fills always go to entry ~mru.
- Lookup, every cycle:
  - addr_l <= pcm_addr.
  - On a hit in either entry: pcm_data <= the selected byte, ok_r <= 1, mru <= the hit entry.
  - On a miss: ok_r <= 0 and pcm_data holds its value.
- pcm_ok = ok_r & (pcm_addr == addr_l). It drops combinationally in the same cycle pcm_addr changes.
- FSM states:
  - IDLE
    - On a miss: sdram_addr <= W, kind <= DEMAND, go to REQ.
    - Otherwise, if pf_pend: sdram_addr <= pf_addr, kind <= PREFETCH, go to REQ.
  - REQ: sdram_req=1. On sdram_ack go to WAIT; sdram_req drops in the cycle after ack.
  - WAIT
    - On sdram_dok: write entry ~mru (tag <= sdram_addr, valid <= 1, data <= sdram_data), set mru to that entry, go to IDLE.
    - On a DEMAND fill with PREFETCH=1: set pf_pend and pf_addr = sdram_addr+1, modulo 2^17 (0x1FFFF wraps to 0x00000).
    - pf_pend is cleared when a prefetch is issued, or in IDLE if pf_addr already hits an entry.
- Demand priority:
  - A miss seen in IDLE always wins over a pending prefetch.
  - A prefetch already in REQ or WAIT is never aborted; the demand miss is issued from IDLE afterwards.
- A prefetch fill that matches the current W produces a hit on the next lookup; no demand is issued for it.
- sdram_dok outside WAIT is ignored; no state change.
- sdram_ack outside REQ is ignored.
- Both entries never hold the same tag: a fill whose tag already matches the other entry invalidates that other entry.

## Timing
- Reset (rst_n=0 at an edge):
  - pcm_data=0, ok_r=0 (so pcm_ok=0), sdram_req=0, sdram_addr=0.
  - State IDLE, both valid bits cleared, mru=0, pf_pend=0.
- Reset mid-transaction drops the request at the next edge. A late dok after reset is ignored (state is IDLE).
- Hit latency: pcm_addr stable at edge N → pcm_ok=1 and pcm_data valid after edge N+1.
- Miss sequence:
  - Miss detected at edge N → state REQ; sdram_req=1 after edge N+1.
  - ack at edge A → sdram_req=0 after A+1.
  - dok at edge D → entry written at D+1 → lookup hit; pcm_ok=1 after D+2.
- Minimum demand cost with ack and dok in consecutive cycles: 4 cycles.
- Same-cycle dok and an address change: the write still completes. The new address is looked up in the next cycle against the updated entries.
- sdram_addr is stable whenever sdram_req=1.

## Test plan
- Reset, then pcm_addr=0x00001, ack 2 cycles after req, dok 3 cycles after ack with data 0xBEEF:
  - sdram_addr=0x00000, a single req pulse train.
  - pcm_data=0xBE and pcm_ok=1 two cycles after dok.
  - Then address 0x00000 gives 0xEF in 1 cycle with no new req.
- PREFETCH=1, demand W=0x00010:
  - A second request for 0x00011 follows without a demand.
  - Stepping pcm_addr through 0x00022..0x00023 is served with no further req.
- Wrap: demand W=0x1FFFF → prefetch sdram_addr=0x00000. Reading byte 0x00000 afterwards hits.
- Demand miss to 0x00100 while a prefetch is in WAIT:
  - The prefetch completes first, then one demand req for 0x00080.
  - pcm_ok stays 0 throughout the wait.
- rst_n low for 1 cycle during WAIT, then dok pulses:
  - Entries stay invalid, sdram_req=0, pcm_ok=0.
  - The next lookup re-issues the request.
- Spurious sdram_dok and sdram_ack in IDLE: no entry or state change, sdram_req stays 0.
